// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared FSM states, default width and counter sizing for the sequential divider
package seq_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DEF_WIDTH = 8;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one combinational restoring-division step producing the next remainder and quotient bit
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  always_comb begin
    shifted  = {rem, q_msb};
    q_bit    = shifted >= {1'b0, divisor};
    rem_next = q_bit ? shifted[WIDTH-1:0] - divisor : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/seq_div8.sv
// seq_div8: iterative unsigned restoring divider with valid/ready handshakes on operands and results
module seq_div8
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (remainder),
    .q_msb    (quotient[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );
  assign in_ready = state == IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvs <= divisor;
          if (divisor == '0) begin
            state       <= DONE;
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            state     <= CALC;
            quotient  <= dividend;
            remainder <= '0;
            cnt       <= CW'(WIDTH - 1);
          end
        end
        CALC: begin
          remainder <= rem_next;
          quotient  <= {quotient[WIDTH-2:0], q_bit};
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        DONE: if (out_valid && out_ready) begin
          state       <= IDLE;
          out_valid   <= 1'b0;
          div_by_zero <= 1'b0;
        end else out_valid <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_div8.md
Name: seq_div8

Overview:
- Iterative unsigned restoring divider. It is the inverse-direction companion to the team's partitioned 8-bit multiplier datapath.
- Accepts a dividend/divisor pair over a valid/ready handshake and computes one quotient bit per cycle.
- Presents quotient, remainder and a divide-by-zero flag over a second valid/ready handshake.
- Used as the exact golden divider and as the baseline for later approximate-divider partitions.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands.
- dividend  input  WIDTH  unsigned dividend; sampled on input handshake.
- divisor  input  WIDTH  unsigned divisor; sampled on input handshake.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.
- div_by_zero  output  1  result came from divisor == 0.

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous, active-high. All state updates occur on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1 (combinational from IDLE), out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. Input handshake (in_valid & in_ready) latches dividend and divisor.
    - divisor != 0 -> CALC; load partial remainder=0, quotient shift register=dividend, counter=WIDTH-1.
    - divisor == 0 -> DONE; quotient=all ones, remainder=dividend, div_by_zero=1.
  - CALC: in_ready=0, out_valid=0. Each cycle performs one restoring step:
    - trial = {rem[WIDTH-2:0], q[WIDTH-1]} - divisor, computed WIDTH+1 bits wide.
    - trial non-negative -> rem=trial[WIDTH-1:0] and shift 1 into q LSB.
    - trial negative -> rem={rem[WIDTH-2:0], q[WIDTH-1]} and shift 0 into q LSB.
    - When counter==0, go to DONE after this step; otherwise decrement the counter.
  - DONE: out_valid=1, in_ready=0. quotient, remainder and div_by_zero are held stable while out_valid & !out_ready. Output handshake (out_valid & out_ready) -> IDLE and div_by_zero cleared.
- Latency: input handshake at edge t.
  - Normal operation: out_valid is high in the cycle following edge t+WIDTH (WIDTH CALC cycles).
  - Divide-by-zero: out_valid is high after edge t+1.
- Throughput: no bypass. After the output handshake at edge u, the next input can be accepted no earlier than edge u+1. Maximum one result per WIDTH+2 cycles.
- Invariants:
  - For divisor != 0: dividend == quotient*divisor + remainder and remainder < divisor.
  - Divide-by-zero result: quotient = 2^WIDTH-1, remainder = dividend.
- Input rules:
  - in_valid while in_ready=0 is ignored; the source must hold it.
  - Operand changes during CALC have no effect.
- Reset mid-operation: rst in CALC or DONE aborts at that edge, discards any pending result, and returns to the reset values; no result is emitted.
- rst has priority over simultaneous handshakes.
- out_ready asserted outside DONE has no effect.

Decomposition:
- Package seq_div_pkg holds:
  - state enum {IDLE, CALC, DONE}, 2-bit encoding.
  - default WIDTH constant.
  - counter-width function clog2(WIDTH).
- Sub-module seq_div_step: combinational single restoring step.
  - Inputs: rem, q MSB, divisor.
  - Outputs: next rem, quotient bit.
  - Instantiated once in the CALC datapath; reusable later for unrolled/approximate variants.

Test Plan:
- 200/7 (WIDTH=8) -> out_valid after WIDTH cycles; quotient=28, remainder=4, div_by_zero=0.
- 255/1 then 3/10 back-to-back with out_ready=1 -> first result 255 r0, second result 0 r3; second in_ready seen only after the first output handshake.
- 5/0 -> out_valid one cycle after accept; quotient=255, remainder=5, div_by_zero=1; next op 9/3 -> 3 r0 with div_by_zero=0.
- 100/9 with out_ready=0 for 5 cycles after out_valid -> outputs stable at 11 r1 throughout; IDLE only after out_ready=1.
- rst asserted on 3rd CALC cycle of 77/4 -> next cycle out_valid=0, in_ready=1; subsequent 77/4 -> 19 r1.
- Random sweep (all 65536 pairs for WIDTH=8) -> invariants hold; count of cycles from accept to out_valid is WIDTH (normal) or 1 (divisor==0).
